// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request channels and register-file write port bundle
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  logic            RegWrite;
  logic [5:0]      WriteReg;
  logic [XLEN-1:0] WriteData;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  RegWrite, WriteReg, WriteData
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output RegWrite, WriteReg, WriteData
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with registered write stage and pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  input  logic [4:0]           chk_rd,
  output logic                 stall,
  output logic [NREGS-1:0]     busy,
  output logic [CNT_W-1:0]     wb_count
);

  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_MEM = 1'b1
  } ptr_t;

  ptr_t            ptr_q, ptr_d;
  logic            grant_alu, grant_mem;
  logic            st_we;
  logic [4:0]      st_rd;
  logic [XLEN-1:0] st_data;
  logic            reg_write;
  logic [NREGS-1:0] busy_d;

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= PTR_ALU;
    else       ptr_q <= ptr_d;
  end

  // Whoever is granted hands priority to the other requester, contested or not.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    ptr_d     = ptr_q;
    if (!reset) begin
      if (wb.alu_valid && (!wb.mem_valid || ptr_q == PTR_ALU)) begin
        grant_alu = 1'b1;
        ptr_d     = PTR_MEM;
      end else if (wb.mem_valid) begin
        grant_mem = 1'b1;
        ptr_d     = PTR_ALU;
      end
    end
  end

  assign wb.alu_ready = grant_alu;
  assign wb.mem_ready = grant_mem;

  // x0 requests are consumed but never raise the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_we   <= 1'b0;
      st_rd   <= 5'd0;
      st_data <= '0;
    end else if (grant_alu) begin
      st_we   <= |wb.alu_rd;
      st_rd   <= wb.alu_rd;
      st_data <= wb.alu_data;
    end else if (grant_mem) begin
      st_we   <= |wb.mem_rd;
      st_rd   <= wb.mem_rd;
      st_data <= wb.mem_data;
    end else begin
      st_we   <= 1'b0;
    end
  end

  // A staged write is dropped if reset arrives while it sits in the output register.
  assign reg_write    = st_we & ~reset;
  assign wb.RegWrite  = reg_write;
  assign wb.WriteReg  = {1'b0, st_rd};
  assign wb.WriteData = st_data;

  // Set is applied after clear so a newer producer stays outstanding.
  always_comb begin
    busy_d = busy;
    if (reg_write)
      busy_d[st_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      wb_count <= '0;
    end else begin
      busy <= busy_d;
      if (reg_write)
        wb_count <= wb_count + CNT_W'(1);
    end
  end

  assign stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

endmodule
